// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_e;

    localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'hF;

    // Byte distance between consecutive instructions.
    function automatic int unsigned PC_INC(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with flush; used both for issued PCs and for the
// instruction queue. The caller never pushes when full unless it also pops.
module fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop_i)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wrPtr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rdPtr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-based requests to a variable-latency
// memory, in-order queue, redirect flush, HALT detection. FETCH_PERF_EN adds counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 WIDTH       = 16,
    parameter int                 ADDR_W      = 16,
    parameter int                 DEPTH       = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [3:0]         HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [WIDTH-1:0]  imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [WIDTH-1:0]  inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              hlt
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_stall
`endif
);

    localparam int                CW  = $clog2(DEPTH) + 1;
    localparam int                DW  = CW + 3;
    localparam int                QW  = WIDTH + ADDR_W;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC(WIDTH));

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DW-1:0]     drop_q, drop_d;

    logic [CW-1:0]     qCount, pcCount;
    logic              qEmpty, pcEmpty;
    logic [QW-1:0]     qHead;
    logic [ADDR_W-1:0] pcHead;
    logic [CW:0]       credit;
    logic              redirectAct, reqValid, fire, rspDrop, rspKeep;
    logic              instValid, pop, rspHalt, headHalt, pcFlush;

    // The PC FIFO holds exactly the live (non-dropped) requests, so its count is the in-flight count.
    assign credit      = {1'b0, qCount} + {1'b0, pcCount};
    assign redirectAct = redirect_valid && (state_q != HALTED);
    assign reqValid    = rst_n && (state_q == RUN) && (credit < (CW+1)'(DEPTH));
    assign fire        = reqValid && imem_req_ready;
    assign rspDrop     = imem_rsp_valid && (drop_q != '0);
    assign rspKeep     = imem_rsp_valid && (drop_q == '0) && !pcEmpty && !redirectAct;
    assign instValid   = rst_n && !qEmpty && (state_q != HALTED);
    assign pop         = instValid && inst_ready;
    assign rspHalt     = rspKeep && (state_q == RUN) &&
                         (imem_rsp_data[WIDTH-1 -: 4] == HALT_OPCODE);
    assign headHalt    = (qHead[QW-1 -: 4] == HALT_OPCODE);
    assign pcFlush     = redirectAct || rspHalt;

    fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pcFifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (pcFlush),
        .push_i      (fire),
        .push_data_i (pc_q),
        .pop_i       (rspKeep),
        .pop_data_o  (pcHead),
        .empty_o     (pcEmpty),
        .count_o     (pcCount)
    );

    fetch_fifo #(.W(QW), .DEPTH(DEPTH)) u_instFifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirectAct),
        .push_i      (rspKeep),
        .push_data_i ({imem_rsp_data, pcHead}),
        .pop_i       (pop),
        .pop_data_o  (qHead),
        .empty_o     (qEmpty),
        .count_o     (qCount)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (redirectAct) begin
            pc_d    = redirect_pc;
            drop_d  = drop_q + DW'(pcCount) + DW'(fire) - DW'(imem_rsp_valid);
            state_d = RUN;
        end else begin
            if (fire)    pc_d   = pc_q + INC;
            if (rspDrop) drop_d = drop_q - 1'b1;
            // Everything issued after the HALT is on a dead path; drop it on return.
            if (rspHalt) begin
                state_d = HALT_PEND;
                drop_d  = DW'(pcCount) + DW'(fire) - 1'b1;
            end else if ((state_q == HALT_PEND) && pop && headHalt) begin
                state_d = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    assign imem_req_valid = reqValid;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = instValid;
    assign inst_data      = qHead[QW-1:ADDR_W];
    assign inst_pc        = qHead[ADDR_W-1:0];
    assign pc             = pc_q;
    assign hlt            = (state_q == HALTED);

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, dropped_q, stall_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else begin
            if (rspKeep && (fetched_q != '1))
                fetched_q <= fetched_q + 1'b1;
            if (imem_rsp_valid && !rspKeep && (dropped_q != '1))
                dropped_q <= dropped_q + 1'b1;
            if ((state_q == RUN) && !instValid && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic [15:0] pc;
    logic        hlt;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .pc             (pc),
        .hlt            (hlt)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_stall     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } memReq_t;

    memReq_t     pendQ[$];
    int          cyc       = 0;
    int          fireCount = 0;
    int          memLat    = 1;
    logic [15:0] haltAddr  = 16'hFFFF;
    logic        fireSeen  = 1'b0;
    logic        rspSeen   = 1'b0;
    logic        rstSeen   = 1'b0;
    logic [15:0] addrSeen  = '0;

    function automatic logic [15:0] memWord(input logic [15:0] addr);
        if (addr == haltAddr) return 16'hF000;
        return {4'h1, addr[11:0]};
    endfunction

    // What the DUT will see at the coming edge, captured while inputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            fireSeen = imem_req_valid && imem_req_ready;
            addrSeen = imem_req_addr;
            rspSeen  = imem_rsp_valid;
            rstSeen  = !rst_n;
        end
    end

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rstSeen) begin
                pendQ.delete();
            end else begin
                if (rspSeen && (pendQ.size() > 0)) void'(pendQ.pop_front());
                if (fireSeen) begin
                    pendQ.push_back('{addrSeen, cyc + memLat - 1});
                    fireCount++;
                end
            end
            if ((pendQ.size() > 0) && (pendQ[0].due <= cyc)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(pendQ[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // One call = one clock cycle; returns at the falling edge for checking.
    task automatic applyStimulus(input logic rstN, input logic memRdy, input logic redirV,
                                 input logic [15:0] redirPc, input logic instRdy);
        @(posedge clk);
        #2;
        rst_n          = rstN;
        imem_req_ready = memRdy;
        redirect_valid = redirV;
        redirect_pc    = redirPc;
        inst_ready     = instRdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int f0;

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;

        applyStimulus(0, 1, 0, 16'h0, 1);
        applyStimulus(0, 1, 0, 16'h0, 1);
        checkOutput("rst_pc",        32'(pc),             32'h0);
        checkOutput("rst_hlt",       32'(hlt),            32'h0);
        checkOutput("rst_inst_vld",  32'(inst_valid),     32'h0);
        checkOutput("rst_req_vld",   32'(imem_req_valid), 32'h0);

        // Back-to-back issue with one-cycle memory.
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("bb_req0_vld",   32'(imem_req_valid), 32'h1);
        checkOutput("bb_req0_addr",  32'(imem_req_addr),  32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("bb_req1_addr",  32'(imem_req_addr),  32'h2);
        checkOutput("bb_inst_early", 32'(inst_valid),     32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("bb_req2_addr",  32'(imem_req_addr),  32'h4);
        checkOutput("bb_inst0_vld",  32'(inst_valid),     32'h1);
        checkOutput("bb_inst0_pc",   32'(inst_pc),        32'h0);
        checkOutput("bb_inst0_data", 32'(inst_data),      32'h1000);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("bb_req3_addr",  32'(imem_req_addr),  32'h6);
        checkOutput("bb_inst1_pc",   32'(inst_pc),        32'h2);
        checkOutput("bb_inst1_data", 32'(inst_data),      32'h1002);

        // Decode stalled: credits cap issue at DEPTH.
        applyStimulus(0, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        f0 = fireCount;
        checkOutput("st_req0_addr",  32'(imem_req_addr),  32'h0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        checkOutput("st_req_stop",   32'(imem_req_valid), 32'h0);
        checkOutput("st_pc",         32'(pc),             32'h8);
        applyStimulus(1, 1, 0, 16'h0, 0);
        checkOutput("st_full_req",   32'(imem_req_valid), 32'h0);
        checkOutput("st_head_vld",   32'(inst_valid),     32'h1);
        checkOutput("st_head_pc",    32'(inst_pc),        32'h0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        checkOutput("st_fire_count", 32'(fireCount - f0), 32'h4);
        checkOutput("st_hold_req",   32'(imem_req_valid), 32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("st_rel_req",    32'(imem_req_valid), 32'h0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        checkOutput("st_resume_vld", 32'(imem_req_valid), 32'h1);
        checkOutput("st_resume_addr",32'(imem_req_addr),  32'h8);
        checkOutput("st_after_pop",  32'(inst_pc),        32'h2);
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 0);
        checkOutput("full_inst_vld", 32'(inst_valid),     32'h1);
        checkOutput("full_req_vld",  32'(imem_req_valid), 32'h0);
        checkOutput("full_pc",       32'(pc),             32'ha);

        // One-cycle reset with a full queue.
        applyStimulus(0, 1, 0, 16'h0, 0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("mid_rst_pc",    32'(pc),             32'h0);
        checkOutput("mid_rst_ivld",  32'(inst_valid),     32'h0);
        checkOutput("mid_rst_hlt",   32'(hlt),            32'h0);
        checkOutput("mid_rst_req",   32'(imem_req_valid), 32'h1);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetched0", perf_fetched,        32'h0);
        checkOutput("perf_dropped0", perf_dropped,        32'h0);
        checkOutput("perf_stall0",   perf_stall,          32'h0);
`endif

        // Redirect with three requests outstanding on a three-cycle memory.
        memLat = 3;
        applyStimulus(0, 1, 0, 16'h0, 1);
        applyStimulus(1, 1, 0, 16'h0, 1);
        applyStimulus(1, 1, 0, 16'h0, 1);
        applyStimulus(1, 1, 0, 16'h0, 1);
        applyStimulus(1, 0, 1, 16'h0040, 1);
        checkOutput("rd_pre_ivld",   32'(inst_valid),     32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("rd_pc",         32'(pc),             32'h40);
        checkOutput("rd_req_vld",    32'(imem_req_valid), 32'h1);
        checkOutput("rd_req_addr",   32'(imem_req_addr),  32'h40);
        checkOutput("rd_q_empty",    32'(inst_valid),     32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("rd_drop_ivld",  32'(inst_valid),     32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("rd_wait_ivld",  32'(inst_valid),     32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("rd_new_ivld",   32'(inst_valid),     32'h1);
        checkOutput("rd_new_pc",     32'(inst_pc),        32'h40);
        checkOutput("rd_new_data",   32'(inst_data),      32'h1040);

        // HALT at PC 8 is delivered, then the core stays halted.
        memLat   = 1;
        haltAddr = 16'h0008;
        applyStimulus(0, 1, 0, 16'h0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("h_head_pc",     32'(inst_pc),        32'h8);
        checkOutput("h_head_data",   32'(inst_data),      32'hf000);
        checkOutput("h_req_stop",    32'(imem_req_valid), 32'h0);
        checkOutput("h_hlt_early",   32'(hlt),            32'h0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("h_hlt",         32'(hlt),            32'h1);
        checkOutput("h_ivld",        32'(inst_valid),     32'h0);
        checkOutput("h_pc",          32'(pc),             32'hc);
        applyStimulus(1, 1, 1, 16'h0200, 1);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("h_redir_hlt",   32'(hlt),            32'h1);
        checkOutput("h_redir_pc",    32'(pc),             32'hc);
        checkOutput("h_redir_req",   32'(imem_req_valid), 32'h0);

        // HALT queued but squashed by a redirect before decode takes it.
        applyStimulus(0, 1, 0, 16'h0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 16'h0, 1);
        applyStimulus(1, 1, 0, 16'h0, 0);
        checkOutput("hp_head_pc",    32'(inst_pc),        32'h8);
        checkOutput("hp_req_stop",   32'(imem_req_valid), 32'h0);
        applyStimulus(1, 1, 1, 16'h0100, 0);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("hp_hlt",        32'(hlt),            32'h0);
        checkOutput("hp_ivld",       32'(inst_valid),     32'h0);
        checkOutput("hp_pc",         32'(pc),             32'h100);
        checkOutput("hp_req_vld",    32'(imem_req_valid), 32'h1);
        checkOutput("hp_req_addr",   32'(imem_req_addr),  32'h100);
        applyStimulus(1, 1, 0, 16'h0, 1);
        applyStimulus(1, 1, 0, 16'h0, 1);
        checkOutput("hp_new_ivld",   32'(inst_valid),     32'h1);
        checkOutput("hp_new_pc",     32'(inst_pc),        32'h100);
        checkOutput("hp_new_data",   32'(inst_data),      32'h1100);
        checkOutput("hp_new_hlt",    32'(hlt),            32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
